snake_dir_input: RTL and testbench

Player-input receiver for the snake game. It conditions the four active-low push-buttons (KEY[3:0] = LEFT, UP, DOWN, RIGHT), debounces each one, and filters presses into a single pending turn. `game_path` consumes that turn once per move step. The block sits between the board KEY pins and `game_path`, and replaces ad-hoc key sampling. It also provides a raw "any key pressed" pulse, which the death and restart states use.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_dir_input_if.sv | 22 ++
 rtl/key_debounce.sv | 49 ++++
 rtl/snake_dir_input.sv | 100 ++++++++++
 tb/tb_snake_dir_input.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: heading encoding, key bit positions and the
// reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    UP    = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_LEFT  = 3;

  // The encoding is chosen so that the reverse heading is the bitwise complement.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/snake_dir_input_if.sv
// Turn/heading handshake between snake_dir_input (slave) and game_path (master).
interface snake_dir_input_if;
  import snake_pkg::*;

  logic game_rst;
  logic step_req;
  dir_t dir;
  logic turned;
  logic pend_valid;
  logic any_press;

  modport master (
    output game_rst, step_req,
    input  dir, turned, pend_valid, any_press
  );

  modport slave (
    input  game_rst, step_req,
    output dir, turned, pend_valid, any_press
  );

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level and a
// rise strobe that coincides with the edge at which the level goes high.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic held,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             flip;

  assign flip = (sync2_reg != stable_reg) && (cnt_reg == CNT_MAX);
  // Combinational so the top level can act on the press at the same edge the
  // debounced level changes.
  assign rise = flip && !stable_reg;
  assign held = stable_reg;

  // Inversion happens ahead of the first flop so a reset value of 0 means released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= ~key_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (flip) begin
        stable_reg <= ~stable_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// Player-input receiver: debounces KEY[3:0], filters presses into a single
// pending turn and commits it to the heading on each move step.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] held,
  snake_dir_input_if.slave    bus
);

  logic [NUM_KEYS-1:0] press;
  dir_t                press_dir;
  logic                press_any;
  logic                press_legal;

  dir_t dir_reg, dir_next;
  dir_t pend_dir_reg, pend_dir_next;
  logic pend_valid_reg, pend_valid_next;
  logic turned_reg, turned_next;
  logic any_press_reg;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_n[gi]),
        .held (held[gi]),
        .rise (press[gi])
      );
    end
  endgenerate

  // Simultaneous presses resolve LEFT > UP > DOWN > RIGHT.
  always_comb begin
    press_any = |press;
    press_dir = RIGHT;
    if (press[KEY_LEFT])      press_dir = LEFT;
    else if (press[KEY_UP])   press_dir = UP;
    else if (press[KEY_DOWN]) press_dir = DOWN;
    else if (press[KEY_RIGHT]) press_dir = RIGHT;
    press_legal = press_any && (press_dir != dir_reg) && (press_dir != opposite(dir_reg));
  end

  always_comb begin
    dir_next        = dir_reg;
    pend_dir_next   = pend_dir_reg;
    pend_valid_next = pend_valid_reg;
    turned_next     = 1'b0;
    if (bus.game_rst) begin
      dir_next        = RIGHT;
      pend_dir_next   = RIGHT;
      pend_valid_next = 1'b0;
    end else if (bus.step_req) begin
      // A press landing on the step cycle beats the queued turn.
      if (press_legal) begin
        dir_next        = press_dir;
        pend_valid_next = 1'b0;
        turned_next     = 1'b1;
      end else if (pend_valid_reg) begin
        dir_next        = pend_dir_reg;
        pend_valid_next = 1'b0;
        turned_next     = 1'b1;
      end
    end else if (press_legal) begin
      pend_dir_next   = press_dir;
      pend_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_reg        <= RIGHT;
      pend_dir_reg   <= RIGHT;
      pend_valid_reg <= 1'b0;
      turned_reg     <= 1'b0;
      any_press_reg  <= 1'b0;
    end else begin
      dir_reg        <= dir_next;
      pend_dir_reg   <= pend_dir_next;
      pend_valid_reg <= pend_valid_next;
      turned_reg     <= turned_next;
      any_press_reg  <= press_any;
    end
  end

  assign bus.dir        = dir_reg;
  assign bus.turned     = turned_reg;
  assign bus.pend_valid = pend_valid_reg;
  assign bus.any_press  = any_press_reg;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed, cycle-accurate bench for snake_dir_input with DEBOUNCE_CYCLES = 4.
module tb_snake_dir_input;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] held;

  snake_dir_input_if bus ();

  snake_dir_input #(.DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .held (held),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] key_n;
    logic       grst;
    logic       step;
    int         n;
    logic [1:0] e_dir;
    logic       e_turned;
    logic       e_pv;
    logic       e_any;
    logic [3:0] e_held;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] k, input logic g, input logic s, input int n,
                              input logic [1:0] d, input logic t, input logic pv,
                              input logic a, input logic [3:0] h);
    vec_t v;
    v.key_n = k; v.grst = g; v.step = s; v.n = n;
    v.e_dir = d; v.e_turned = t; v.e_pv = pv; v.e_any = a; v.e_held = h;
    return v;
  endfunction

  // One clock, then compare every output against the expected set.
  task automatic tick(input string name, input logic [1:0] e_dir, input logic e_t,
                      input logic e_pv, input logic e_any, input logic [3:0] e_held);
    logic [1:0] got_dir;
    @(posedge clk);
    #1;
    got_dir = bus.dir;
    n_tests++;
    if (got_dir !== e_dir || bus.turned !== e_t || bus.pend_valid !== e_pv ||
        bus.any_press !== e_any || held !== e_held) begin
      n_fail++;
      $display("FAIL %s: got dir=%0d turned=%b pend_valid=%b any_press=%b held=%b, expected dir=%0d turned=%b pend_valid=%b any_press=%b held=%b",
               name, got_dir, bus.turned, bus.pend_valid, bus.any_press, held,
               e_dir, e_t, e_pv, e_any, e_held);
    end
  endtask

  initial begin
    // key_n, grst, step, cycles | dir, turned, pend_valid, any_press, held
    vecs.push_back(mk(4'b1101, 0, 0, 5, 0, 0, 0, 0, 4'b0000)); // DOWN debouncing
    vecs.push_back(mk(4'b1101, 0, 0, 1, 0, 0, 1, 1, 4'b0010)); // accepted, queued
    vecs.push_back(mk(4'b1111, 0, 1, 1, 1, 1, 0, 0, 4'b0010)); // commit DOWN
    vecs.push_back(mk(4'b1111, 0, 0, 4, 1, 0, 0, 0, 4'b0010));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 1, 0, 0, 0, 4'b0000)); // release seen
    vecs.push_back(mk(4'b0011, 0, 0, 5, 1, 0, 0, 0, 4'b0000)); // LEFT+UP together
    vecs.push_back(mk(4'b0011, 0, 0, 1, 1, 0, 1, 1, 4'b1100)); // LEFT wins, legal
    vecs.push_back(mk(4'b1111, 0, 0, 5, 1, 0, 1, 0, 4'b1100));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 1, 0, 1, 0, 4'b0000));
    vecs.push_back(mk(4'b1110, 0, 0, 5, 1, 0, 1, 0, 4'b0000)); // RIGHT press
    vecs.push_back(mk(4'b1110, 0, 0, 1, 1, 0, 1, 1, 4'b0001)); // replaces LEFT
    vecs.push_back(mk(4'b1111, 0, 1, 1, 0, 1, 0, 0, 4'b0001)); // commit RIGHT
    vecs.push_back(mk(4'b1111, 0, 0, 4, 0, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(4'b0111, 0, 0, 5, 0, 0, 0, 0, 4'b0000)); // LEFT = reversal
    vecs.push_back(mk(4'b0111, 0, 0, 1, 0, 0, 0, 1, 4'b1000)); // dropped
    vecs.push_back(mk(4'b1110, 0, 0, 5, 0, 0, 0, 0, 4'b1000)); // LEFT up, RIGHT down
    vecs.push_back(mk(4'b1110, 0, 0, 1, 0, 0, 0, 1, 4'b0001)); // same dir dropped
    vecs.push_back(mk(4'b1111, 0, 1, 1, 0, 0, 0, 0, 4'b0001)); // step, no candidate
    vecs.push_back(mk(4'b1111, 0, 0, 4, 0, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(4'b1011, 0, 0, 5, 0, 0, 0, 0, 4'b0000)); // UP press
    vecs.push_back(mk(4'b1011, 0, 1, 1, 2, 1, 0, 1, 4'b0100)); // press+step commit
    vecs.push_back(mk(4'b1111, 0, 0, 5, 2, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 2, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(4'b1110, 0, 0, 5, 2, 0, 0, 0, 4'b0000)); // RIGHT from UP
    vecs.push_back(mk(4'b1110, 0, 0, 1, 2, 0, 1, 1, 4'b0001));
    vecs.push_back(mk(4'b1111, 0, 1, 1, 0, 1, 0, 0, 4'b0001)); // first step consumes
    vecs.push_back(mk(4'b1111, 0, 1, 1, 0, 0, 0, 0, 4'b0001)); // second step: nothing
    vecs.push_back(mk(4'b1111, 0, 0, 3, 0, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(4'b1101, 0, 0, 5, 0, 0, 0, 0, 4'b0000)); // DOWN queued again
    vecs.push_back(mk(4'b1101, 0, 0, 1, 0, 0, 1, 1, 4'b0010));
    vecs.push_back(mk(4'b1111, 1, 1, 1, 0, 0, 0, 0, 4'b0010)); // game_rst beats step
    vecs.push_back(mk(4'b1111, 0, 0, 4, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 0, 0, 0, 0, 4'b0000));

    rst_n        = 1'b0;
    key_n        = 4'b1111;
    bus.game_rst = 1'b0;
    bus.step_req = 1'b0;
    tick("reset", 2'd0, 0, 0, 0, 4'b0000);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) tick($sformatf("idle%0d", c), 2'd0, 0, 0, 0, 4'b0000);
    $display("[TB] reset + 20 idle cycles checked");

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        key_n        = vecs[i].key_n;
        bus.game_rst = vecs[i].grst;
        bus.step_req = vecs[i].step;
        tick($sformatf("vec%0d.%0d", i, c), vecs[i].e_dir, vecs[i].e_turned,
             vecs[i].e_pv, vecs[i].e_any, vecs[i].e_held);
      end
      $display("[TB] vec %0d key_n=%b game_rst=%b step_req=%b x%0d -> dir=%0d held=%b",
               i, vecs[i].key_n, vecs[i].grst, vecs[i].step, vecs[i].n,
               vecs[i].e_dir, vecs[i].e_held);
    end
    bus.game_rst = 1'b0;
    bus.step_req = 1'b0;

    // Glitch: three samples low is one short of acceptance.
    key_n = 4'b1101;
    for (int c = 0; c < 3; c++) tick($sformatf("glitch_lo%0d", c), 2'd0, 0, 0, 0, 4'b0000);
    key_n = 4'b1111;
    for (int c = 0; c < 7; c++) tick($sformatf("glitch_hi%0d", c), 2'd0, 0, 0, 0, 4'b0000);
    $display("[TB] glitch of 3 samples rejected check done");

    // Reset with the DOWN counter at 2: needs a fresh full debounce afterwards.
    key_n = 4'b1101;
    for (int c = 0; c < 4; c++) tick($sformatf("middeb_pre%0d", c), 2'd0, 0, 0, 0, 4'b0000);
    rst_n = 1'b0;
    tick("middeb_rst", 2'd0, 0, 0, 0, 4'b0000);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick($sformatf("middeb_post%0d", c), 2'd0, 0, 0, 0, 4'b0000);
    tick("middeb_accept", 2'd0, 0, 1, 1, 4'b0010);
    tick("middeb_after", 2'd0, 0, 1, 0, 4'b0010);
    $display("[TB] mid-debounce reset sequence checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
